ssd_scan_ctrl: RTL

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_pkg.sv | 14 +
 rtl/ssd_scan_ctrl_dec.sv | 31 +++
 rtl/ssd_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and scan FSM state encoding for the seven-segment scan controller
package ssd_pkg;

    localparam int NUM_DIGITS_DEF = 4;

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic       DP_OFF  = 1'b1;

endpackage

// File: rtl/ssd_scan_ctrl_dec.sv
// rtl/ssd_scan_ctrl_dec.sv - hex nibble to active-low seven-segment pattern (gfedcba)
module ssd_scan_ctrl_dec (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup; the caller registers the result.
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous update; SSD_SCAN_GUARD_EN adds inter-slot blanking
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIV        = 50000,
    parameter int GUARD      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    pend
);

    localparam int                PW       = $clog2(DIV);
    localparam int                PTRW     = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam logic [PTRW-1:0]   PTR_LAST = PTRW'(NUM_DIGITS - 1);

    // Out-of-range GUARD is a configuration error; this block exists only to make that visible in elaboration listings.
    if (GUARD < 1 || GUARD > 255) begin : g_guard_out_of_range
    end

    logic [PW-1:0]           presc;
    logic [PTRW-1:0]         ptr;
    logic                    showing;
    logic                    tick;
    logic                    advance;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] act_d;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [4*NUM_DIGITS-1:0] pnd_d;
    logic [NUM_DIGITS-1:0]   pnd_dp;
    logic [NUM_DIGITS-1:0]   pnd_blank;

    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    lit;

`ifdef SSD_SCAN_GUARD_EN
    localparam logic [0:0] S_SHOW     = ST_SHOW;
    localparam logic [0:0] S_GUARD    = ST_GUARD;
    localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);

    logic [0:0] state;
    logic [7:0] gcnt;

    assign showing = (state == S_SHOW);
    assign tick    = showing && (presc == PRE_LAST);
    assign advance = (state == S_GUARD) && (gcnt == GUARD_LAST);

    // Slot timing: lit for DIV cycles, dark for GUARD cycles, pointer steps on re-entry to SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SHOW;
            presc <= '0;
            gcnt  <= '0;
            ptr   <= '0;
        end else if (state == S_SHOW) begin
            if (tick) begin
                presc <= '0;
                gcnt  <= '0;
                state <= S_GUARD;
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            if (advance) begin
                state <= S_SHOW;
                ptr   <= (ptr == PTR_LAST) ? '0 : ptr + PTRW'(1);
            end else begin
                gcnt <= gcnt + 8'd1;
            end
        end
    end
`else
    assign showing = 1'b1;
    assign tick    = (presc == PRE_LAST);
    assign advance = tick;

    // Slot timing: exactly DIV cycles per digit, pointer steps straight on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            ptr   <= '0;
        end else if (tick) begin
            presc <= '0;
            ptr   <= (ptr == PTR_LAST) ? '0 : ptr + PTRW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end
`endif

    assign boundary = advance && (ptr == PTR_LAST);

    // Double-buffered digit data: active only changes as the pointer wraps, so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d     <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            pnd_d     <= '0;
            pnd_dp    <= '0;
            pnd_blank <= '0;
            pend      <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                act_d     <= din;
                act_dp    <= dp_in;
                act_blank <= blank_in;
                pnd_d     <= din;
                pnd_dp    <= dp_in;
                pnd_blank <= blank_in;
            end else if (pend) begin
                act_d     <= pnd_d;
                act_dp    <= pnd_dp;
                act_blank <= pnd_blank;
            end
            pend <= 1'b0;
        end else if (load) begin
            pnd_d     <= din;
            pnd_dp    <= dp_in;
            pnd_blank <= blank_in;
            pend      <= 1'b1;
        end
    end

    assign nib = act_d[{ptr, 2'b00} +: 4];
    assign lit = showing && !act_blank[ptr];

    ssd_scan_ctrl_dec u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Pin registers: one cycle behind state and pointer, dark whenever the slot is guarded or blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else if (lit) begin
            an  <= ~(NUM_DIGITS'(1) << ptr);
            seg <= dec_seg;
            dp  <= ~act_dp[ptr];
        end else begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end
    end

endmodule
